// File: rtl/egress_fifo_reader_pkg.sv
// Shared definitions for the egress FIFO read-side controller.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package egress_fifo_reader_pkg;

  // FSM state encodings, kept as plain constants for compatibility with older code.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADR    = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // Ceiling log2 for elaboration-time width calculations (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/egress_fifo_reader_rr_arbiter.sv
// Rotate-priority search: first requesting queue at or after i_rr_ptr, wrapping at nr_of_queues.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module egress_fifo_reader_rr_arbiter #(
  parameter int nr_of_queues = 16,
  parameter int a_hi_size    = 4
) (
  input  logic [nr_of_queues-1:0] i_req,
  input  logic [a_hi_size-1:0]    i_rr_ptr,
  output logic                    o_any,
  output logic [a_hi_size-1:0]    o_gnt_idx
);

  // Scan offsets from farthest to nearest so the nearest requester is the final winner.
  always_comb begin
    int k;
    o_any     = 1'b0;
    o_gnt_idx = '0;
    for (int i = nr_of_queues - 1; i >= 0; i--) begin
      k = (int'(i_rr_ptr) + i) % nr_of_queues;
      if (i_req[k]) begin
        o_any     = 1'b1;
        o_gnt_idx = a_hi_size'(k);
      end
    end
  end

endmodule

// File: rtl/egress_fifo_reader.sv
// Read-side controller of the multi-queue egress FIFO: round-robin grant, read strobes, data realignment.
// Latency: strobe cycle to dout_valid is rd_latency+1 cycles; one beat per cycle within a burst.
// Backpressure: dout_ready is sampled only when granting; a started burst always runs to completion.
module egress_fifo_reader
  import egress_fifo_reader_pkg::*;
#(
  parameter int nr_of_queues = 16,
  parameter int a_hi_size    = 4,
  parameter int data_width   = 36,
  parameter int burst_len    = 4,
  parameter int rd_latency   = 3,
  parameter int holdoff      = 2
) (
  input  logic                    clk2,
  input  logic                    rst2,
  input  logic [0:nr_of_queues-1] fifo_empty,
  input  logic [0:nr_of_queues-1] fifo_flag,
  output logic                    read_adr,
  output logic                    read_data,
  output logic [0:nr_of_queues-1] read_enable,
  input  logic [data_width-1:0]   q,
  input  logic                    dout_ready,
  output logic [data_width-1:0]   dout,
  output logic                    dout_valid,
  output logic [a_hi_size-1:0]    dout_queue,
  output logic                    dout_last
);

  // Word counter must hold burst_len itself, hence the extra bit.
  localparam int CW = clog2(burst_len) + 1;
  localparam int HW = clog2(holdoff + 1) + 1;

  logic [1:0]              r_state;
  logic [a_hi_size-1:0]    r_rr_ptr;
  logic [a_hi_size-1:0]    r_gnt_idx;
  logic [CW-1:0]           r_len;
  logic [CW-1:0]           r_word;
  logic [HW-1:0]           r_hold;

  logic [nr_of_queues-1:0] w_req;
  logic                    w_any;
  logic [a_hi_size-1:0]    w_gnt;
  logic [a_hi_size-1:0]    w_next_ptr;
  logic                    w_strobe;
  logic                    w_last;

  // Tag pipeline, stage rd_latency-1 lines up with the word on q.
  logic [rd_latency-1:0]                r_pv;
  logic [rd_latency-1:0]                r_pl;
  logic [rd_latency-1:0][a_hi_size-1:0] r_pq;

  // Request vector: a queue asks for service whenever it is not empty (bit i = queue i).
  always_comb begin
    w_req = '0;
    for (int i = 0; i < nr_of_queues; i++) w_req[i] = ~fifo_empty[i];
  end

  egress_fifo_reader_rr_arbiter #(
    .nr_of_queues (nr_of_queues),
    .a_hi_size    (a_hi_size)
  ) u_arb (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_any     (w_any),
    .o_gnt_idx (w_gnt)
  );

  assign w_next_ptr = (int'(w_gnt) == nr_of_queues - 1) ? '0 : w_gnt + 1'b1;
  assign w_strobe   = (r_state == ST_ADR) || (r_state == ST_DATA);
  assign w_last     = w_strobe && (r_word == r_len - 1'b1);
  assign read_adr   = (r_state == ST_ADR);
  assign read_data  = (r_state == ST_DATA);

  // Queue select is one-hot on the granted queue during the first-word strobe only.
  always_comb begin
    read_enable = '0;
    for (int i = 0; i < nr_of_queues; i++) begin
      if ((r_state == ST_ADR) && (int'(r_gnt_idx) == i)) read_enable[i] = 1'b1;
    end
  end

  // Grant FSM. The IDLE arbitration cycle counts as the last holdoff cycle, so SETTLE
  // lasts holdoff-1 cycles and back-to-back grants are 1+(len-1)+holdoff cycles apart.
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_len     <= '0;
      r_word    <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dout_ready && w_any) begin
            r_state   <= ST_ADR;
            r_gnt_idx <= w_gnt;
            r_len     <= fifo_flag[w_gnt] ? CW'(burst_len) : CW'(1);
            r_rr_ptr  <= w_next_ptr;
            r_word    <= '0;
          end
        end
        ST_ADR, ST_DATA: begin
          r_word <= r_word + 1'b1;
          if (w_last) begin
            if (holdoff > 1) begin
              r_state <= ST_SETTLE;
              r_hold  <= HW'(holdoff - 2);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_SETTLE: begin
          if (r_hold == '0) r_state <= ST_IDLE;
          else              r_hold  <= r_hold - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shift a {valid, queue, last} tag per strobe; reset drops anything in flight.
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      r_pv <= '0;
      r_pl <= '0;
      r_pq <= '0;
    end else begin
      r_pv[0] <= w_strobe;
      r_pl[0] <= w_last;
      r_pq[0] <= r_gnt_idx;
      for (int i = 1; i < rd_latency; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pq[i] <= r_pq[i-1];
      end
    end
  end

  // Output register: capture q alongside the tag that arrives with it.
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_queue <= '0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= r_pv[rd_latency-1];
      dout_queue <= r_pq[rd_latency-1];
      dout_last  <= r_pl[rd_latency-1] & r_pv[rd_latency-1];
      if (r_pv[rd_latency-1]) dout <= q;
    end
  end

endmodule

// File: tb/tb_egress_fifo_reader.sv
// Bench for egress_fifo_reader: directed queue patterns, FIFO read model and scoreboard.
// Latency: main DUT rd_latency=3; extra instances at rd_latency=1 and 5 for timing only.
// Backpressure: dout_ready held low to stall grants, then released.
module tb_egress_fifo_reader;

  localparam int NQ = 16;
  localparam int AW = 4;
  localparam int DW = 36;

  logic          clk2 = 1'b0;
  logic          rst2;
  logic [0:NQ-1] fifo_empty;
  logic [0:NQ-1] fifo_flag;
  logic          dout_ready;
  logic [DW-1:0] q;
  logic [DW-1:0] q_zero;

  logic          read_adr, read_data, dout_valid, dout_last;
  logic [0:NQ-1] read_enable;
  logic [DW-1:0] dout;
  logic [AW-1:0] dout_queue;

  logic          l1_adr, l1_data, l1_valid, l1_last;
  logic [0:NQ-1] l1_en;
  logic [DW-1:0] l1_dout;
  logic [AW-1:0] l1_queue;
  logic          l5_adr, l5_data, l5_valid, l5_last;
  logic [0:NQ-1] l5_en;
  logic [DW-1:0] l5_dout;
  logic [AW-1:0] l5_queue;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [AW-1:0] qid;
    logic [DW-1:0] dat;
    logic          last;
  } exp_t;
  exp_t sb[$];

  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc <= cyc + 1;
  assign q_zero = '0;

  egress_fifo_reader #(.rd_latency(3)) dut (
    .clk2(clk2), .rst2(rst2), .fifo_empty(fifo_empty), .fifo_flag(fifo_flag),
    .read_adr(read_adr), .read_data(read_data), .read_enable(read_enable), .q(q),
    .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_queue(dout_queue), .dout_last(dout_last)
  );

  egress_fifo_reader #(.rd_latency(1)) u_lat1 (
    .clk2(clk2), .rst2(rst2), .fifo_empty(fifo_empty), .fifo_flag(fifo_flag),
    .read_adr(l1_adr), .read_data(l1_data), .read_enable(l1_en), .q(q_zero),
    .dout_ready(dout_ready), .dout(l1_dout), .dout_valid(l1_valid),
    .dout_queue(l1_queue), .dout_last(l1_last)
  );

  egress_fifo_reader #(.rd_latency(5)) u_lat5 (
    .clk2(clk2), .rst2(rst2), .fifo_empty(fifo_empty), .fifo_flag(fifo_flag),
    .read_adr(l5_adr), .read_data(l5_data), .read_enable(l5_en), .q(q_zero),
    .dout_ready(dout_ready), .dout(l5_dout), .dout_valid(l5_valid),
    .dout_queue(l5_queue), .dout_last(l5_last)
  );

  // FIFO read model: word = {queue, per-queue sequence number}, returned 3 cycles after its strobe.
  logic [AW-1:0] m_cur, m_sel;
  logic [DW-1:0] m_pipe [3];
  logic [31:0]   m_seq  [NQ];

  always_comb begin
    m_sel = m_cur;
    if (read_adr) begin
      for (int i = 0; i < NQ; i++) if (read_enable[i]) m_sel = AW'(i);
    end
  end

  always @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      m_cur <= '0;
      for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
      for (int i = 0; i < NQ; i++) m_seq[i] <= '0;
    end else begin
      if (read_adr) m_cur <= m_sel;
      if (read_adr || read_data) begin
        m_pipe[0]    <= {m_sel, m_seq[m_sel]};
        m_seq[m_sel] <= m_seq[m_sel] + 1;
      end else begin
        m_pipe[0] <= '0;
      end
      m_pipe[1] <= m_pipe[0];
      m_pipe[2] <= m_pipe[1];
    end
  end
  assign q = m_pipe[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] wd(input int qi, input int s);
    return {AW'(qi), 32'(s)};
  endfunction

  task automatic push(input int qi, input int s, input logic last);
    exp_t e;
    e.qid  = AW'(qi);
    e.dat  = wd(qi, s);
    e.last = last;
    sb.push_back(e);
  endtask

  function automatic int oh2idx(input logic [0:NQ-1] v);
    for (int i = 0; i < NQ; i++) if (v[i]) return i;
    return 99;
  endfunction

  // Advance at least one cycle, then until the chosen strobe is seen (bounded).
  task automatic wait_for(input bit data_strobe, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk2);
      n++;
    end while (((data_strobe ? read_data : read_adr) !== 1'b1) && n < 60);
    check(nm, data_strobe ? read_data : read_adr, 1);
  endtask

  // Monitor: every beat the DUT presents must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk2);
      if (dout_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: beat queue=%0d dout=%0h, required no beat", dout_queue, dout);
        end else begin
          e = sb.pop_front();
          check("sb_dout", dout, e.dat);
          check("sb_queue", dout_queue, e.qid);
          check("sb_last", dout_last, e.last);
        end
      end
    end
  end

  initial begin
    int k, nv, ns, f_main, f1, f5, n1, last_cyc, idx;
    int fair_q [6];
    logic [0:NQ-1] oh;

    fair_q = '{2, 9, 15, 2, 9, 15};
    rst2 = 1'b1;
    fifo_empty = '1;
    fifo_flag  = '0;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk2);

    // Reset state
    check("rst_read_adr", read_adr, 0);
    check("rst_read_data", read_data, 0);
    check("rst_read_enable", read_enable, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_queue", dout_queue, 0);
    check("rst_dout_last", dout_last, 0);
    rst2 = 1'b0;

    // Test 1: reset in the middle of a burst
    fifo_flag[5] = 1'b1;
    fifo_empty[5] = 1'b0;
    wait_for(1, "t1_data_seen");
    rst2 = 1'b1;
    #1;
    check("t1_read_adr", read_adr, 0);
    check("t1_read_data", read_data, 0);
    check("t1_read_enable", read_enable, 0);
    check("t1_dout_valid", dout_valid, 0);
    fifo_empty[5] = 1'b1;
    fifo_flag[5] = 1'b0;
    repeat (2) @(negedge clk2);
    rst2 = 1'b0;
    ns = 0;
    nv = 0;
    repeat (10) begin
      @(negedge clk2);
      if (read_adr || read_data) ns++;
      if (dout_valid) nv++;
    end
    check("t1_idle_strobes", ns, 0);
    check("t1_no_beats", nv, 0);

    // Test 2: single-word grant on queue 3
    fifo_empty[3] = 1'b0;
    push(3, 0, 1'b1);
    wait_for(0, "t2_adr");
    oh = '0;
    oh[3] = 1'b1;
    check("t2_read_enable", read_enable, oh);
    fifo_empty[3] = 1'b1;
    for (k = 1; k <= 4; k++) begin
      @(negedge clk2);
      if (k == 1) check("t2_no_data_strobe", read_data, 0);
      if (k == 3) check("t2_valid_early", dout_valid, 0);
      if (k == 4) check("t2_valid_at_4", dout_valid, 1);
    end
    repeat (8) @(negedge clk2);

    // Test 3 + latency sweep: burst on queue 5
    fifo_flag[5] = 1'b1;
    fifo_empty[5] = 1'b0;
    for (int s = 0; s < 4; s++) push(5, s, s == 3);
    wait_for(0, "t3_adr");
    fifo_empty[5] = 1'b1;
    fifo_flag[5] = 1'b0;
    nv = 0; n1 = 0; f_main = -1; f1 = -1; f5 = -1;
    for (k = 1; k <= 7; k++) begin
      @(negedge clk2);
      if (k <= 4) check("t3_read_data", read_data, (k <= 3) ? 1 : 0);
      check("t3_read_adr_low", read_adr, 0);
      if (dout_valid) begin nv++; if (f_main < 0) f_main = k; end
      if (l1_valid) begin
        n1++;
        if (f1 < 0) f1 = k;
        check("t6_lat1_queue", l1_queue, 5);
        check("t6_lat1_last", l1_last, (n1 == 4) ? 1 : 0);
      end
      if (l5_valid && f5 < 0) f5 = k;
    end
    check("t3_beats", nv, 4);
    check("t3_first_beat", f_main, 4);
    check("t6_lat1_delay", f1, 2);
    check("t6_lat5_delay", f5, 6);
    check("t6_lat5_queue", l5_queue, 5);
    repeat (8) @(negedge clk2);

    // Test 5: backpressure holds off grants
    dout_ready = 1'b0;
    fifo_empty[0] = 1'b0;
    ns = 0;
    repeat (20) begin
      @(negedge clk2);
      if (read_adr || read_data) ns++;
    end
    check("t5_no_strobe", ns, 0);
    push(0, 0, 1'b1);
    dout_ready = 1'b1;
    @(negedge clk2);
    check("t5_adr_next", read_adr, 1);
    check("t5_queue", oh2idx(read_enable), 0);
    fifo_empty[0] = 1'b1;
    repeat (8) @(negedge clk2);

    // Test 6: pointer at 1, queues 15 and 0 pending -> 15 first, then wrap to 0
    fifo_empty[0] = 1'b0;
    fifo_empty[15] = 1'b0;
    push(15, 0, 1'b1);
    push(0, 1, 1'b1);
    wait_for(0, "t6_adr_a");
    check("t6_first_q15", oh2idx(read_enable), 15);
    fifo_empty[15] = 1'b1;
    wait_for(0, "t6_adr_b");
    check("t6_wrap_q0", oh2idx(read_enable), 0);
    fifo_empty[0] = 1'b1;
    repeat (8) @(negedge clk2);

    // Test 4: fairness among queues 2, 9, 15
    fifo_empty[2] = 1'b0;
    fifo_empty[9] = 1'b0;
    fifo_empty[15] = 1'b0;
    push(2, 0, 1'b1); push(9, 0, 1'b1); push(15, 1, 1'b1);
    push(2, 1, 1'b1); push(9, 1, 1'b1); push(15, 2, 1'b1);
    last_cyc = 0;
    for (int g = 0; g < 6; g++) begin
      wait_for(0, "t4_adr");
      idx = oh2idx(read_enable);
      check("t4_order", idx, fair_q[g]);
      if (g > 0) check("t4_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      if (g == 5) begin
        fifo_empty[2] = 1'b1;
        fifo_empty[9] = 1'b1;
        fifo_empty[15] = 1'b1;
      end
    end
    repeat (12) @(negedge clk2);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
